// File: rtl/div_pipe_unsigned_if.sv
// div_pipe_unsigned_if
//   Handshake/data bundle for the pipelined unsigned divider.
//   master : operand source / result sink (drives ce and the in_* fields)
//   slave  : the divider (drives the out_* fields)
//   Signals:
//     ce          pipeline enable (all stages advance when 1, hold when 0)
//     in_valid    operand valid, sampled only when ce=1
//     in_dividend unsigned dividend, DW bits
//     in_divisor  unsigned divisor, DW bits
//     in_tag      opaque sideband, TW bits
//     out_valid   result valid; transfer on out_valid=1 and ce=1
//     out_quot    quotient, DW bits
//     out_rem     remainder, DW bits
//     out_dbz     divisor was zero
//     out_tag     tag returned with the result
interface div_pipe_unsigned_if #(
  parameter int DW = 16,
  parameter int TW = 8
) ();
  logic          ce;
  logic          in_valid;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic [DW-1:0] out_quot;
  logic [DW-1:0] out_rem;
  logic          out_dbz;
  logic [TW-1:0] out_tag;

  modport master (
    output ce, in_valid, in_dividend, in_divisor, in_tag,
    input  out_valid, out_quot, out_rem, out_dbz, out_tag
  );

  modport slave (
    input  ce, in_valid, in_dividend, in_divisor, in_tag,
    output out_valid, out_quot, out_rem, out_dbz, out_tag
  );
endinterface

// File: rtl/div_pipe_unsigned.sv
// div_pipe_unsigned
//   Fully pipelined unsigned restoring divider. One dividend/divisor pair is
//   accepted per enabled cycle; quotient, remainder, divide-by-zero flag and
//   the sideband tag appear DW+1 enabled cycles later.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (wins over ce and in_valid)
//     bus  div_pipe_unsigned_if.slave (ce, in_*, out_*)
//   Structure: stage 0 input register, stages 1..DW one restoring step each,
//   then the output register. No combinational input-to-output path.
module div_pipe_unsigned #(
  parameter int DW = 16,
  parameter int TW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  div_pipe_unsigned_if.slave     bus
);

  // Per-stage state. The partial remainder is kept DW bits wide: its top bit
  // is provably 0 at every stage output, so only the in-flight trial value
  // inside div_step needs DW+1 bits.
  logic [DW:0]   valid_q, valid_d;
  logic [DW:0]   dbz_q, dbz_d;
  logic [DW-1:0] r_q   [0:DW];
  logic [DW-1:0] r_d   [0:DW];
  logic [DW-1:0] q_q   [0:DW];
  logic [DW-1:0] q_d   [0:DW];
  logic [DW-1:0] dvs_q [0:DW];
  logic [DW-1:0] dvs_d [0:DW];
  logic [DW-1:0] dvd_q [0:DW];
  logic [DW-1:0] dvd_d [0:DW];
  logic [TW-1:0] tag_q [0:DW];
  logic [TW-1:0] tag_d [0:DW];

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_quot_q, out_quot_d;
  logic [DW-1:0] out_rem_q, out_rem_d;
  logic          out_dbz_q, out_dbz_d;
  logic [TW-1:0] out_tag_q, out_tag_d;

  // One restoring step: shift the next dividend bit into the remainder, then
  // subtract the divisor if it fits. Returns {new_r, new_q}. When t >= d the
  // true difference is below d, so the low DW bits of t - d are exact.
  function automatic logic [2*DW-1:0] div_step(
    input logic [DW-1:0] r,
    input logic [DW-1:0] q,
    input logic [DW-1:0] d
  );
    logic [DW:0]   t;
    logic [DW-1:0] r_new;
    logic          fits;
    t     = {r, q[DW-1]};
    fits  = (t >= {1'b0, d});
    if (fits) begin
      r_new = t[DW-1:0] - d;
    end else begin
      r_new = t[DW-1:0];
    end
    return {r_new, q[DW-2:0], fits};
  endfunction

  // Next-state for every stage and the output register; everything holds
  // when ce=0, data fields load only behind an incoming valid.
  always_comb begin
    valid_d     = valid_q;
    dbz_d       = dbz_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_dbz_d   = out_dbz_q;
    out_tag_d   = out_tag_q;

    if (bus.ce) begin
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        r_d[0]   = {DW{1'b0}};
        q_d[0]   = bus.in_dividend;
        dvs_d[0] = bus.in_divisor;
        dvd_d[0] = bus.in_dividend;
        tag_d[0] = bus.in_tag;
        dbz_d[0] = (bus.in_divisor == {DW{1'b0}});
      end else begin
        valid_d[0] = 1'b0;
      end

      for (int k = 1; k <= DW; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          {r_d[k], q_d[k]} = div_step(r_q[k-1], q_q[k-1], dvs_q[k-1]);
          dvs_d[k] = dvs_q[k-1];
          dvd_d[k] = dvd_q[k-1];
          tag_d[k] = tag_q[k-1];
          dbz_d[k] = dbz_q[k-1];
        end else begin
          dbz_d[k] = dbz_q[k];
        end
      end

      out_valid_d = valid_q[DW];
      if (valid_q[DW]) begin
        // Zero divisor: force the documented result rather than relying on
        // the restoring iteration happening to produce it.
        if (dbz_q[DW]) begin
          out_quot_d = {DW{1'b1}};
          out_rem_d  = dvd_q[DW];
        end else begin
          out_quot_d = q_q[DW];
          out_rem_d  = r_q[DW];
        end
        out_dbz_d = dbz_q[DW];
        out_tag_d = tag_q[DW];
      end else begin
        out_dbz_d = out_dbz_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset that clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= {(DW+1){1'b0}};
      dbz_q       <= {(DW+1){1'b0}};
      for (int k = 0; k <= DW; k++) begin
        r_q[k]   <= {DW{1'b0}};
        q_q[k]   <= {DW{1'b0}};
        dvs_q[k] <= {DW{1'b0}};
        dvd_q[k] <= {DW{1'b0}};
        tag_q[k] <= {TW{1'b0}};
      end
      out_valid_q <= 1'b0;
      out_quot_q  <= {DW{1'b0}};
      out_rem_q   <= {DW{1'b0}};
      out_dbz_q   <= 1'b0;
      out_tag_q   <= {TW{1'b0}};
    end else begin
      valid_q     <= valid_d;
      dbz_q       <= dbz_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dbz_q   <= out_dbz_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_quot  = out_quot_q;
  assign bus.out_rem   = out_rem_q;
  assign bus.out_dbz   = out_dbz_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_div_pipe_unsigned.sv
// tb_div_pipe_unsigned
//   Scoreboard bench for div_pipe_unsigned at DW=8, TW=8. Stimulus pushes the
//   hand-computed expected result on every accepted input edge; a negedge
//   monitor pops and compares on every transfer (out_valid=1 and ce=1).
module tb_div_pipe_unsigned;
  localparam int DW = 8;
  localparam int TW = 8;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic [TW-1:0] tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_pipe_unsigned_if #(.DW(DW), .TW(TW)) bus ();
  div_pipe_unsigned #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_t sb[$];
  res_t exp_s;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;

  // Scoreboard push: record the expectation of every operation the DUT accepts.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (bus.ce && bus.in_valid) begin
      sb.push_back(exp_s);
    end
  end

  // Monitor: pop and compare on each transfer.
  always @(negedge clk) begin
    res_t got;
    res_t e;
    if (!rst && bus.out_valid && bus.ce) begin
      got = '{bus.out_quot, bus.out_rem, bus.out_dbz, bus.out_tag};
      n_xfer++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got q=%0d r=%0d dbz=%0d tag=%0h, required no result",
                 got.q, got.r, got.dbz, got.tag);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL result: got q=%0d r=%0d dbz=%0d tag=%0h, required q=%0d r=%0d dbz=%0d tag=%0h",
                   got.q, got.r, got.dbz, got.tag, e.q, e.r, e.dbz, e.tag);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag,
                       input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic ed);
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = tag;
    exp_s           = '{eq, er, ed, tag};
    bus.in_valid    = 1'b1;
    bus.ce          = 1'b1;
    step();
    bus.in_valid    = 1'b0;
  endtask

  // Step until out_valid is seen, bounded; returns cycles stepped.
  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.out_valid && cyc < 40);
    if (!bus.out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no out_valid in %0d cycles, required a result", name, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c0;
    int x0;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    rst             = 1'b1;
    bus.ce          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_tag      = '0;
    exp_s           = '0;
    step();
    step();
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_quot", {24'd0, bus.out_quot}, 32'd0);
    chk("rst_rem", {24'd0, bus.out_rem}, 32'd0);
    chk("rst_dbz", {31'd0, bus.out_dbz}, 32'd0);
    chk("rst_tag", {24'd0, bus.out_tag}, 32'd0);
    rst = 1'b0;
    bus.ce = 1'b1;
    step();

    // Basic 200/7: latency DW+1, single-cycle pulse.
    issue(8'd200, 8'd7, 8'h11, 8'd28, 8'd4, 1'b0);
    wait_valid("basic", c);
    chk("basic_latency", c, 32'd9);
    chk("basic_quot", {24'd0, bus.out_quot}, 32'd28);
    step();
    chk("basic_pulse", {31'd0, bus.out_valid}, 32'd0);

    // Corners back-to-back: four consecutive results.
    issue(8'd255, 8'd1,   8'h21, 8'd255, 8'd0, 1'b0);
    issue(8'd5,   8'd9,   8'h22, 8'd0,   8'd5, 1'b0);
    issue(8'd255, 8'd255, 8'h23, 8'd1,   8'd0, 1'b0);
    issue(8'd0,   8'd3,   8'h24, 8'd0,   8'd0, 1'b0);
    wait_valid("corner", c);
    chk("corner_first", c, 32'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("corner_run", {31'd0, bus.out_valid}, 32'd1);
    end
    step();
    chk("corner_end", {31'd0, bus.out_valid}, 32'd0);

    // Divide by zero, then a normal op right behind it.
    issue(8'd100, 8'd0, 8'h30, 8'hFF, 8'd100, 1'b0 | 1'b1);
    issue(8'd9,   8'd3, 8'h31, 8'd3,  8'd0,   1'b0);
    wait_valid("dbz", c);
    chk("dbz_flag", {31'd0, bus.out_dbz}, 32'd1);
    chk("dbz_rem", {24'd0, bus.out_rem}, 32'd100);
    step();
    chk("dbz_next_flag", {31'd0, bus.out_dbz}, 32'd0);
    chk("dbz_next_quot", {24'd0, bus.out_quot}, 32'd3);
    repeat (2) step();

    // Stall mid-flight for 3 cycles, then stall on the output.
    issue(8'd200, 8'd7, 8'h40, 8'd28, 8'd4, 1'b0);
    repeat (2) step();
    bus.ce = 1'b0;
    repeat (3) step();
    bus.ce = 1'b1;
    wait_valid("stall", c);
    chk("stall_latency", c + 5, 32'd12);
    bus.ce = 1'b0;
    x0 = n_xfer;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_quot", {24'd0, bus.out_quot}, 32'd28);
      chk("hold_tag", {24'd0, bus.out_tag}, 32'h40);
    end
    bus.ce = 1'b1;
    step();
    chk("hold_single_xfer", n_xfer - x0, 32'd1);
    chk("hold_release", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) step();

    // Reset mid-operation: two ops in flight, third presented with rst.
    issue(8'd50, 8'd5, 8'h50, 8'd10, 8'd0, 1'b0);
    issue(8'd51, 8'd5, 8'h51, 8'd10, 8'd1, 1'b0);
    bus.in_dividend = 8'd52;
    bus.in_divisor  = 8'd5;
    bus.in_tag      = 8'h52;
    exp_s           = '{8'd10, 8'd2, 1'b0, 8'h52};
    bus.in_valid    = 1'b1;
    rst             = 1'b1;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_quot", {24'd0, bus.out_quot}, 32'd0);
    chk("midrst_rem", {24'd0, bus.out_rem}, 32'd0);
    chk("midrst_tag", {24'd0, bus.out_tag}, 32'd0);
    issue(8'd60, 8'd7, 8'h53, 8'd8, 8'd4, 1'b0);
    wait_valid("postrst", c);
    chk("postrst_latency", c, 32'd9);
    chk("postrst_tag", {24'd0, bus.out_tag}, 32'h53);
    step();

    // Randomised ce/in_valid with a division reference model.
    c0 = 0;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      bus.in_dividend = a;
      bus.in_divisor  = b;
      bus.in_tag      = 8'(c0);
      if (b == 8'd0) begin
        exp_s = '{8'hFF, a, 1'b1, 8'(c0)};
      end else begin
        exp_s = '{a / b, a % b, 1'b0, 8'(c0)};
      end
      bus.ce       = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 1) == 1);
      if (bus.ce && bus.in_valid) begin
        c0++;
      end
      step();
    end
    bus.ce       = 1'b1;
    bus.in_valid = 1'b0;
    repeat (20) step();
    chk("drain_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
